// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register with valid/ready handshake, stall and flush.
// Define EXE_MEM_SKID_EN to build the 2-entry skid-buffer variant with a registered in_ready.
module exe_mem_stage #(
   parameter int PC_W   = 7,
   parameter int DATA_W = 32,
   parameter int WB_W   = 2,
   parameter int MEM_W  = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   addPc,
   input  logic [DATA_W-1:0] aluResult,
   input  logic              zero,
   input  logic [DATA_W-1:0] readData2,
   input  logic [DATA_W-1:0] muxInst,
   input  logic [WB_W-1:0]   WB,
   input  logic [MEM_W-1:0]  MEM,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   addPcOut,
   output logic [DATA_W-1:0] aluResultOut,
   output logic              zeroOut,
   output logic [DATA_W-1:0] readData2Out,
   output logic [DATA_W-1:0] muxInstOut,
   output logic [WB_W-1:0]   WBOut,
   output logic [MEM_W-1:0]  MEMOut
);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] alu;
      logic              zero;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] inst;
      logic [WB_W-1:0]   wb;
      logic [MEM_W-1:0]  mem;
   } entry_t;

   // Handshake: an entry moves in when in_valid && in_ready at posedge and out when
   // out_valid && out_ready at posedge; a held out_valid entry never changes until it moves.
   entry_t in_entry;
   entry_t main_q;
   logic   main_valid;
   logic   accept;
   logic   load_main;

   assign in_entry  = {addPc, aluResult, zero, readData2, muxInst, WB, MEM};
   assign accept    = in_valid && in_ready;
   assign load_main = !main_valid || out_ready;

`ifdef EXE_MEM_SKID_EN
   entry_t skid_q;
   logic   skid_valid;

   // in_ready depends only on state, so out_ready never reaches it combinationally.
   assign in_ready = !skid_valid;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         main_valid <= 1'b0;
         main_q     <= '0;
         skid_valid <= 1'b0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (load_main) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q     <= in_entry;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= in_entry;
         skid_valid <= 1'b1;
      end
   end
`else
   assign in_ready = !main_valid || out_ready;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         main_valid <= 1'b0;
         main_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
      end else if (load_main) begin
         main_valid <= accept;
         if (accept) main_q <= in_entry;
      end
   end
`endif

   assign out_valid    = main_valid;
   assign addPcOut     = main_q.pc;
   assign aluResultOut = main_q.alu;
   assign zeroOut      = main_q.zero;
   assign readData2Out = main_q.rd2;
   assign muxInstOut   = main_q.inst;
   // Control bundles are masked so an empty stage is a bubble with no write or store.
   assign WBOut        = main_valid ? main_q.wb  : '0;
   assign MEMOut       = main_valid ? main_q.mem : '0;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: directed reset/stream/stall/flush/reset cases then random traffic.
// Build with EXE_MEM_SKID_EN defined to exercise the skid-buffer variant.
module tb_exe_mem_stage;

   localparam int W = 7 + 32 * 3 + 1 + 2 + 3;
`ifdef EXE_MEM_SKID_EN
   localparam int SKID = 1;
`else
   localparam int SKID = 0;
`endif

   logic        clock = 1'b0;
   logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [6:0]  addPc, addPcOut;
   logic [31:0] aluResult, readData2, muxInst, aluResultOut, readData2Out, muxInstOut;
   logic        zero, zeroOut;
   logic [1:0]  WB, WBOut;
   logic [2:0]  MEM, MEMOut;

   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   string        phase = "init";
   bit           rst_seen = 1'b0;
   logic         dut_in_fire;
   int           b_taken;

   exe_mem_stage dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .addPc(addPc), .aluResult(aluResult), .zero(zero), .readData2(readData2),
      .muxInst(muxInst), .WB(WB), .MEM(MEM),
      .out_valid(out_valid), .out_ready(out_ready),
      .addPcOut(addPcOut), .aluResultOut(aluResultOut), .zeroOut(zeroOut),
      .readData2Out(readData2Out), .muxInstOut(muxInstOut), .WBOut(WBOut), .MEMOut(MEMOut)
   );

   always #5 clock = ~clock;

   wire [W-1:0] out_pack = {addPcOut, aluResultOut, zeroOut, readData2Out, muxInstOut, WBOut, MEMOut};
   wire [W-1:0] in_pack  = {addPc, aluResult, zero, readData2, muxInst, WB, MEM};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] alu);
      in_valid  = v;
      aluResult = alu;
      addPc     = 7'($urandom_range(0, 127));
      zero      = 1'($urandom_range(0, 1));
      readData2 = $urandom;
      muxInst   = $urandom;
      WB        = 2'($urandom_range(0, 3));
      MEM       = 3'($urandom_range(0, 7));
   endtask

   // Called with inputs settled in the low clock phase; checks outputs, advances the model, crosses one posedge.
   task automatic step();
      logic exp_rdy;
      #1;
      exp_rdy = (SKID != 0) ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready);
      if (rst_seen) begin
         check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
         check("in_ready", 128'(in_ready), 128'(exp_rdy));
         if (exp_q.size() != 0) begin
            check("payload", 128'(out_pack), 128'(exp_q[0]));
         end else begin
            check("wb_bubble", 128'(WBOut), 128'(0));
            check("mem_bubble", 128'(MEMOut), 128'(0));
         end
      end
      dut_in_fire = in_valid && in_ready;
      if (!reset_n) begin
         exp_q.delete();
         rst_seen = 1'b1;
      end else if (flush) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
         if (in_valid && exp_rdy) exp_q.push_back(in_pack);
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b1, 32'hDEAD_0000);

      phase = "reset";
      MEM = 3'b111;
      repeat (2) step();
      reset_n = 1'b1;
      in_valid = 1'b0;
      repeat (2) step();

      phase = "stream";
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'(i));
         step();
         check("latency", 128'(aluResultOut), 128'(i));
      end
      in_valid = 1'b0;
      step();

      phase = "stall";
      out_ready = 1'b0;
      drive(1'b1, 32'hA5A5_0001);
      step();
      drive(1'b1, 32'h0000_0002);
      b_taken = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (dut_in_fire) begin
            b_taken++;
            in_valid = 1'b0;
         end
         check("a_held", 128'(aluResultOut), 128'(32'hA5A5_0001));
      end
      check("b_taken", 128'(b_taken), 128'(SKID));
      check("ready_stalled", 128'(in_ready), 128'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (dut_in_fire) in_valid = 1'b0;
      end

      phase = "flush";
      out_ready = 1'b0;
      drive(1'b1, 32'hA5A5_0003);
      step();
      drive(1'b1, 32'h0000_0004);
      step();
      drive(1'b1, 32'h0000_CCCC);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("flush_valid", 128'(out_valid), 128'(0));
      check("flush_ready", 128'(in_ready), 128'(1));
      repeat (3) step();

      phase = "reset_stall";
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_EEEE);
      step();
      in_valid = 1'b0;
      repeat (2) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("rst_valid", 128'(out_valid), 128'(0));
      drive(1'b1, 32'h0000_1234);
      step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("d_valid", 128'(out_valid), 128'(1));
      check("d_data", 128'(aluResultOut), 128'(32'h0000_1234));
      step();

      phase = "random";
      for (int i = 0; i < 10000; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 63) == 0);
         step();
      end
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
